// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control slice: opcodes, ALU/forward
// encodings and the decoded control bundle.
package ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_BR   = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '{
        alu_op:     2'b00,
        alu_src:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        branch:     1'b0
    };

    // Only formats that actually read rs2 may cause an rs2 load-use hazard.
    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_R) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode to control-bundle decoder.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode_i,
    output ctrl_bundle_t ctrl_o
);

    // Opcode table; anything unrecognised decodes to a NOP bundle.
    always_comb begin
        ctrl_o = CTRL_NOP;
        case (opcode_i)
            OPC_R: begin
                ctrl_o.alu_op    = ALU_FUNC;
                ctrl_o.reg_write = 1'b1;
            end
            OPC_I_ALU: begin
                ctrl_o.alu_op    = ALU_FUNC;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_o.alu_op = ALU_BR;
                ctrl_o.branch = 1'b1;
            end
            default: ctrl_o = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ID->EX->MEM->WB control pipeline with load-use stall and forwarding selects.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW    = 5,
    parameter bit          HAZARD_EN = 1'b1,
    parameter bit          FWD_EN    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [6:0]        opcode_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [1:0]        ex_alu_op_o,
    output logic              ex_alu_src_o,
    output logic [REG_AW-1:0] ex_rs1_o,
    output logic [REG_AW-1:0] ex_rs2_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [REG_AW-1:0] mem_rd_o,
    output logic              wb_reg_write_o,
    output logic              wb_mem_to_reg_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              id_branch_o
);

    localparam logic [REG_AW-1:0] X0 = {REG_AW{1'b0}};

    ctrl_bundle_t      dec_s;
    logic              stall_s;
    logic              bubble_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;

    logic [1:0]        ex_alu_op_d,  ex_alu_op_q;
    logic              ex_alu_src_d, ex_alu_src_q;
    logic              ex_mem_read_d, ex_mem_read_q;
    logic              ex_mem_write_d, ex_mem_write_q;
    logic              ex_reg_write_d, ex_reg_write_q;
    logic              ex_mem_to_reg_d, ex_mem_to_reg_q;
    logic [REG_AW-1:0] ex_rs1_d, ex_rs1_q;
    logic [REG_AW-1:0] ex_rs2_d, ex_rs2_q;
    logic [REG_AW-1:0] ex_rd_d,  ex_rd_q;

    logic              mem_read_d, mem_read_q;
    logic              mem_write_d, mem_write_q;
    logic              mem_reg_write_d, mem_reg_write_q;
    logic              mem_mem_to_reg_d, mem_mem_to_reg_q;
    logic [REG_AW-1:0] mem_rd_d, mem_rd_q;

    logic              wb_reg_write_d, wb_reg_write_q;
    logic              wb_mem_to_reg_d, wb_mem_to_reg_q;
    logic [REG_AW-1:0] wb_rd_d, wb_rd_q;

    ctrl_decode u_decode (
        .opcode_i (opcode_i),
        .ctrl_o   (dec_s)
    );

    // EX/MEM wins over MEM/WB because it carries the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              m_rw,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_rw,
        input logic [REG_AW-1:0] w_rd
    );
        logic [1:0] sel;
        if (m_rw && (m_rd != X0) && (m_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (w_rw && (w_rd != X0) && (w_rd == rs)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Load-use hazard detection; a pending flush discards the dependent anyway.
    always_comb begin
        stall_s = 1'b0;
        if (HAZARD_EN) begin
            stall_s = ex_mem_read_q && (ex_rd_q != X0) && !flush_i &&
                      ((ex_rd_q == rs1_i) || (uses_rs2(opcode_i) && (ex_rd_q == rs2_i)));
        end else begin
            stall_s = 1'b0;
        end
    end

    // Forwarding selects for the instruction currently in EX.
    always_comb begin
        fwd_a_s = FWD_RF;
        fwd_b_s = FWD_RF;
        if (FWD_EN) begin
            fwd_a_s = fwd_sel(ex_rs1_q, mem_reg_write_q, mem_rd_q, wb_reg_write_q, wb_rd_q);
            fwd_b_s = fwd_sel(ex_rs2_q, mem_reg_write_q, mem_rd_q, wb_reg_write_q, wb_rd_q);
        end else begin
            fwd_a_s = FWD_RF;
            fwd_b_s = FWD_RF;
        end
    end

    assign bubble_s = flush_i | stall_s;

    // Next-state for all stage registers; a bubble zeroes the whole ID/EX entry.
    always_comb begin
        ex_alu_op_d     = ALU_ADD;
        ex_alu_src_d    = 1'b0;
        ex_mem_read_d   = 1'b0;
        ex_mem_write_d  = 1'b0;
        ex_reg_write_d  = 1'b0;
        ex_mem_to_reg_d = 1'b0;
        ex_rs1_d        = X0;
        ex_rs2_d        = X0;
        ex_rd_d         = X0;
        if (!bubble_s) begin
            ex_alu_op_d     = dec_s.alu_op;
            ex_alu_src_d    = dec_s.alu_src;
            ex_mem_read_d   = dec_s.mem_read;
            ex_mem_write_d  = dec_s.mem_write;
            ex_reg_write_d  = dec_s.reg_write;
            ex_mem_to_reg_d = dec_s.mem_to_reg;
            ex_rs1_d        = rs1_i;
            ex_rs2_d        = rs2_i;
            ex_rd_d         = rd_i;
        end else begin
            ex_alu_op_d     = ALU_ADD;
            ex_rd_d         = X0;
        end
        mem_read_d       = ex_mem_read_q;
        mem_write_d      = ex_mem_write_q;
        mem_reg_write_d  = ex_reg_write_q;
        mem_mem_to_reg_d = ex_mem_to_reg_q;
        mem_rd_d         = ex_rd_q;
        wb_reg_write_d   = mem_reg_write_q;
        wb_mem_to_reg_d  = mem_mem_to_reg_q;
        wb_rd_d          = mem_rd_q;
    end

    // Stage registers; reset drops every in-flight bundle to NOP.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_alu_op_q      <= ALU_ADD;
            ex_alu_src_q     <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_reg_write_q   <= 1'b0;
            ex_mem_to_reg_q  <= 1'b0;
            ex_rs1_q         <= X0;
            ex_rs2_q         <= X0;
            ex_rd_q          <= X0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_rd_q         <= X0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_rd_q          <= X0;
        end else begin
            ex_alu_op_q      <= ex_alu_op_d;
            ex_alu_src_q     <= ex_alu_src_d;
            ex_mem_read_q    <= ex_mem_read_d;
            ex_mem_write_q   <= ex_mem_write_d;
            ex_reg_write_q   <= ex_reg_write_d;
            ex_mem_to_reg_q  <= ex_mem_to_reg_d;
            ex_rs1_q         <= ex_rs1_d;
            ex_rs2_q         <= ex_rs2_d;
            ex_rd_q          <= ex_rd_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            mem_rd_q         <= mem_rd_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_mem_to_reg_q  <= wb_mem_to_reg_d;
            wb_rd_q          <= wb_rd_d;
        end
    end

    assign stall_o         = stall_s;
    assign fwd_a_o         = fwd_a_s;
    assign fwd_b_o         = fwd_b_s;
    // Gated by reset so every output reads 0 while reset is held.
    assign id_branch_o     = dec_s.branch & rst_i;
    assign ex_alu_op_o     = ex_alu_op_q;
    assign ex_alu_src_o    = ex_alu_src_q;
    assign ex_rs1_o        = ex_rs1_q;
    assign ex_rs2_o        = ex_rs2_q;
    assign ex_rd_o         = ex_rd_q;
    assign mem_read_o      = mem_read_q;
    assign mem_write_o     = mem_write_q;
    assign mem_rd_o        = mem_rd_q;
    assign wb_reg_write_o  = wb_reg_write_q;
    assign wb_mem_to_reg_o = wb_mem_to_reg_q;
    assign wb_rd_o         = wb_rd_q;

endmodule
